stream_gearbox: RTL and testbench

//  Byte-granular wide-to-narrow stream width converter with valid/ready on both sides.

---
 rtl/stream_gearbox_pkg.sv | 24 ++
 rtl/gearbox_byte_buf.sv | 67 ++++++
 rtl/stream_gearbox.sv | 171 +++++++++++++++++
 tb/tb_stream_gearbox.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_gearbox_pkg.sv
// Shared sizing defaults and configuration helpers for the stream_gearbox width converter.
package stream_gearbox_pkg;

   localparam int IN_W_DEF      = 512;
   localparam int OUT_MAX_W_DEF = 64;
   localparam int CNT_W_DEF     = 32;

   localparam int IN_B      = IN_W_DEF / 8;
   localparam int OUT_MAX_B = OUT_MAX_W_DEF / 8;
   localparam int CAP       = IN_B + 2 * OUT_MAX_B - 1;
   localparam int OCC_W     = $clog2(CAP + 1);

   // Out-of-range width requests (zero or above the maximum) fall back to the maximum width.
   function automatic logic [15:0] clamp_bytes(input logic [15:0] req, input logic [15:0] max_b);
      logic [15:0] res;
      if ((req == 16'd0) || (req > max_b)) begin
         res = max_b;
      end else begin
         res = req;
      end
      return res;
   endfunction

endpackage

// File: rtl/gearbox_byte_buf.sv
// Byte shift buffer for stream_gearbox: pops drop bytes from the head, pushes append a word after the survivors.
module gearbox_byte_buf
   import stream_gearbox_pkg::*;
#(
   parameter int IN_BYTES   = IN_B,
   parameter int HEAD_BYTES = OUT_MAX_B,
   parameter int BUF_CAP    = CAP,
   parameter int OCC_BITS   = OCC_W,
   parameter int POP_BITS   = $clog2(OUT_MAX_B) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [IN_BYTES*8-1:0]   push_data,
   input  logic                    pop,
   input  logic [POP_BITS-1:0]     pop_bytes,
   output logic [OCC_BITS-1:0]     occ,
   output logic [HEAD_BYTES*8-1:0] head
);

   localparam int BUF_W = BUF_CAP * 8;

   // Bytes at or above occ are always zero, so an append is a plain OR.
   logic [BUF_W-1:0]    data_r;
   logic [BUF_W-1:0]    shifted_s;
   logic [BUF_W-1:0]    data_next_s;
   logic [OCC_BITS-1:0] occ_r;
   logic [OCC_BITS-1:0] occ_pop_s;
   logic [OCC_BITS-1:0] occ_next_s;

   // Next buffer image: apply the pop first, then append the pushed word behind what remains.
   always_comb begin
      shifted_s   = data_r;
      occ_pop_s   = occ_r;
      data_next_s = data_r;
      occ_next_s  = occ_r;
      if (pop) begin
         shifted_s = data_r >> {pop_bytes, 3'b000};
         occ_pop_s = occ_r - OCC_BITS'(pop_bytes);
      end else begin
         shifted_s = data_r;
         occ_pop_s = occ_r;
      end
      if (push) begin
         data_next_s = shifted_s | (BUF_W'(push_data) << {occ_pop_s, 3'b000});
         occ_next_s  = occ_pop_s + OCC_BITS'(IN_BYTES);
      end else begin
         data_next_s = shifted_s;
         occ_next_s  = occ_pop_s;
      end
   end

   // Buffer storage and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_r <= '0;
         occ_r  <= '0;
      end else begin
         data_r <= data_next_s;
         occ_r  <= occ_next_s;
      end
   end

   assign occ  = occ_r;
   assign head = data_r[HEAD_BYTES*8-1:0];

endmodule

// File: rtl/stream_gearbox.sv
// Wide-to-narrow byte stream gearbox with registered output beat and beat counter.
// Optional frame flush with m_last/m_keep is enabled by defining STREAM_GEARBOX_LAST_EN.
module stream_gearbox
   import stream_gearbox_pkg::*;
#(
   parameter int IN_W      = IN_W_DEF,
   parameter int OUT_MAX_W = OUT_MAX_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(OUT_MAX_W/8):0]  cfg_out_bytes,
   input  logic [IN_W-1:0]               s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic                          s_last,
   output logic [OUT_MAX_W-1:0]          m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_last,
   output logic [OUT_MAX_W/8-1:0]        m_keep,
   output logic [CNT_W-1:0]              beat_cnt
);

   localparam int IN_BYTES  = IN_W / 8;
   localparam int OUT_BYTES = OUT_MAX_W / 8;
   localparam int BUF_CAP   = IN_BYTES + 2 * OUT_BYTES - 1;
   localparam int OCC_BITS  = $clog2(BUF_CAP + 1);
   localparam int BW        = $clog2(OUT_BYTES) + 1;

   logic [OCC_BITS-1:0]  occ_s;
   logic [OUT_MAX_W-1:0] head_s;
   logic [15:0]          occ_ext_s;
   logic [15:0]          cur_ext_s;
   logic [BW-1:0]        cur_r;
   logic [BW-1:0]        pop_n_s;
   logic                 flush_s;
   logic                 idle_s;
   logic                 s_ready_s;
   logic                 push_s;
   logic                 m_fire_s;
   logic                 final_s;
   logic                 head_ok_s;
   logic                 load_s;
   logic [OUT_BYTES-1:0] keep_s;
   logic [OUT_MAX_W-1:0] beat_s;
   logic                 m_valid_r;
   logic [OUT_MAX_W-1:0] m_data_r;
   logic [OUT_BYTES-1:0] m_keep_r;
   logic                 m_last_r;
   logic [CNT_W-1:0]     beat_cnt_r;

   gearbox_byte_buf #(
      .IN_BYTES   (IN_BYTES),
      .HEAD_BYTES (OUT_BYTES),
      .BUF_CAP    (BUF_CAP),
      .OCC_BITS   (OCC_BITS),
      .POP_BITS   (BW)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (s_data),
      .pop       (load_s),
      .pop_bytes (pop_n_s),
      .occ       (occ_s),
      .head      (head_s)
   );

`ifdef STREAM_GEARBOX_LAST_EN
   logic flush_r;

   // Frame flush: armed by the last input word, released when the closing beat is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_r <= 1'b0;
      end else if (push_s && s_last) begin
         flush_r <= 1'b1;
      end else if (m_fire_s && m_last_r) begin
         flush_r <= 1'b0;
      end else begin
         flush_r <= flush_r;
      end
   end

   assign flush_s = flush_r;
`else
   logic unused_last_s;
   assign unused_last_s = s_last;
   assign flush_s       = 1'b0;
`endif

   // Handshake decisions, pop sizing and formatting of the next output beat.
   always_comb begin
      occ_ext_s = 16'(occ_s);
      cur_ext_s = 16'(cur_r);
      idle_s    = (occ_s == OCC_BITS'(0)) && !flush_s;
      s_ready_s = (occ_ext_s < {cur_ext_s[14:0], 1'b0}) && !flush_s;
      push_s    = s_valid && s_ready_s;
      m_fire_s  = m_valid_r && m_ready;
      final_s   = flush_s && (occ_ext_s <= cur_ext_s);
      head_ok_s = (occ_ext_s >= cur_ext_s) || (flush_s && (occ_s != OCC_BITS'(0)));
      load_s    = head_ok_s && (!m_valid_r || m_ready);
      keep_s    = '0;
      beat_s    = '0;
      if (final_s) begin
         pop_n_s = BW'(occ_s);
      end else begin
         pop_n_s = cur_r;
      end
      for (int i = 0; i < OUT_BYTES; i++) begin
         keep_s[i]       = (i < int'(pop_n_s));
         beat_s[8*i +: 8] = keep_s[i] ? head_s[8*i +: 8] : 8'h00;
      end
   end

   // Output width only changes while nothing is buffered and no frame is closing.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_r <= BW'(1);
      end else if (idle_s) begin
         cur_r <= BW'(clamp_bytes(16'(cfg_out_bytes), 16'(OUT_BYTES)));
      end else begin
         cur_r <= cur_r;
      end
   end

   // Output register refills in the same cycle it is drained to sustain one beat per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid_r <= 1'b0;
         m_data_r  <= '0;
         m_keep_r  <= '0;
         m_last_r  <= 1'b0;
      end else if (load_s) begin
         m_valid_r <= 1'b1;
         m_data_r  <= beat_s;
         m_keep_r  <= keep_s;
         m_last_r  <= final_s;
      end else if (m_fire_s) begin
         m_valid_r <= 1'b0;
         m_data_r  <= m_data_r;
         m_keep_r  <= m_keep_r;
         m_last_r  <= m_last_r;
      end else begin
         m_valid_r <= m_valid_r;
         m_data_r  <= m_data_r;
         m_keep_r  <= m_keep_r;
         m_last_r  <= m_last_r;
      end
   end

   // Count of output beats accepted downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_r <= '0;
      end else if (m_fire_s) begin
         beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   assign s_ready  = s_ready_s;
   assign m_valid  = m_valid_r;
   assign m_data   = m_data_r;
   assign m_keep   = m_keep_r;
   assign m_last   = m_last_r;
   assign beat_cnt = beat_cnt_r;

endmodule

// File: tb/tb_stream_gearbox.sv
// Directed self-checking bench for stream_gearbox with a byte-queue scoreboard.
module tb_stream_gearbox;

   logic         clk;
   logic         rst;
   logic [3:0]   cfg_out_bytes;
   logic [511:0] s_data;
   logic         s_valid;
   logic         s_ready;
   logic         s_last;
   logic [63:0]  m_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic [7:0]   m_keep;
   logic [31:0]  beat_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  q[$];
   int          exp_bytes;
   int          beats;
   int          n_push;
   int          wnext;
   int          salt;
   int          cyc = 0;
   int          first_push_cyc;
   int          first_pop_cyc;
   int          last_pop_cyc;
   logic        last_pend;
   logic [7:0]  last_keep;
   logic        last_last;
   logic [63:0] beat_log[128];

   stream_gearbox dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_out_bytes (cfg_out_bytes),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_last        (s_last),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_last        (m_last),
      .m_keep        (m_keep),
      .beat_cnt      (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] mk_word(input int w);
      logic [511:0] d;
      for (int b = 0; b < 64; b++) begin
         d[8*b +: 8] = 8'((w * 64 + b + salt) & 255);
      end
      return d;
   endfunction

   // One clock: score handshakes seen before the edge, then advance and check the hold rule.
   task automatic step();
      logic        push_now;
      logic        pop_now;
      logic        hold_arm;
      logic [63:0] hold_data;
      logic [7:0]  hold_keep;
      int          n;
      logic [63:0] exp_d;
      logic [7:0]  exp_k;
      logic        exp_l;
      push_now  = s_valid && s_ready && !rst;
      pop_now   = m_valid && m_ready && !rst;
      hold_arm  = m_valid && !m_ready && !rst;
      hold_data = m_data;
      hold_keep = m_keep;
      if (pop_now) begin
         n = (q.size() < exp_bytes) ? q.size() : exp_bytes;
         exp_d = '0;
         for (int i = 0; i < n; i++) begin
            exp_d[8*i +: 8] = q.pop_front();
         end
         exp_k = 8'((32'd1 << n) - 32'd1);
         exp_l = 1'b0;
`ifdef STREAM_GEARBOX_LAST_EN
         if (last_pend && (q.size() == 0)) begin
            exp_l     = 1'b1;
            last_pend = 1'b0;
         end
`endif
         check("beat_data", m_data, exp_d);
         check("beat_keep", m_keep, exp_k);
         check("beat_last", m_last, exp_l);
         if (beats < 128) beat_log[beats] = m_data;
         if (beats == 0) first_pop_cyc = cyc;
         last_pop_cyc = cyc;
         last_keep    = m_keep;
         last_last    = m_last;
         beats++;
      end
      if (push_now) begin
         for (int b = 0; b < 64; b++) q.push_back(s_data[8*b +: 8]);
         if (s_last) last_pend = 1'b1;
         if (n_push == 0) first_push_cyc = cyc;
         n_push++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hold_arm && !rst) begin
         check("hold", {m_valid, m_keep, m_data}, {1'b1, hold_keep, hold_data});
      end
   endtask

   task automatic clear_model();
      q.delete();
      beats     = 0;
      n_push    = 0;
      wnext     = 0;
      last_pend = 1'b0;
   endtask

   task automatic reset_dut();
      rst     = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      clear_model();
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // Feed nw words and run until the total beat count reaches target (bounded).
   task automatic run(input int nw, input int vmode, input int rmode, input logic lastf, input int target);
      int   w = 0;
      int   t = 0;
      logic pushed;
      while ((beats < target) && (t < 4000)) begin
         s_valid = (w < nw) && ((vmode == 0) || ($urandom_range(1, 0) == 1));
         s_data  = mk_word(wnext);
         s_last  = lastf && (w == nw - 1);
         m_ready = (rmode == 0) ? 1'b1 : ($urandom_range(1, 0) == 1);
         pushed  = s_valid && s_ready;
         step();
         if (pushed) begin
            w++;
            wnext++;
         end
         t++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (beats != target) check("run_timeout", 128'(beats), 128'(target));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      salt          = 0;
      exp_bytes     = 7;
      cfg_out_bytes = 4'd7;
      s_data        = '0;
      clear_model();
      reset_dut();

      check("rst_s_ready", s_ready, 1'b1);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_m_data", m_data, 64'h0);
      check("rst_m_keep", m_keep, 8'h00);
      check("rst_m_last", m_last, 1'b0);
      check("rst_beat_cnt", beat_cnt, 32'h0);

      // Back-to-back 7 words at 7 bytes per beat.
      run(7, 0, 0, 1'b0, 64);
      check("t1_latency", 128'(first_pop_cyc - first_push_cyc), 128'(2));
      check("t1_consecutive", 128'(last_pop_cyc - first_pop_cyc), 128'(63));
      check("t1_beat0", beat_log[0], 64'h0006050403020100);
      check("t1_beat63", beat_log[63], 64'h00BFBEBDBCBBBAB9);
      check("t1_beat_cnt", beat_cnt, 32'd64);

      // One word leaves one residual byte that carries into the next word.
      reset_dut();
      run(1, 0, 0, 1'b0, 9);
      idle(4);
      check("t2_m_valid", m_valid, 1'b0);
      check("t2_beat_cnt", beat_cnt, 32'd9);
      check("t2_s_ready", s_ready, 1'b1);
      run(1, 0, 0, 1'b0, 10);
      check("t2_beat10", beat_log[9], 64'h004544434241403F);

      // Random valid/ready with 5-byte beats.
      reset_dut();
      cfg_out_bytes = 4'd5;
      exp_bytes     = 5;
      salt          = 17;
      run(10, 1, 1, 1'b0, 128);
      idle(3);
      check("t3_beat_cnt", beat_cnt, 32'd128);
      check("t3_queue_empty", 128'(q.size()), 128'(0));

      // Width change mid-stream applies only after drain; zero request maps to maximum.
      reset_dut();
      salt          = 0;
      cfg_out_bytes = 4'd7;
      exp_bytes     = 7;
      run(1, 0, 0, 1'b0, 1);
      cfg_out_bytes = 4'd4;
      run(6, 0, 0, 1'b0, 64);
      idle(2);
      exp_bytes = 4;
      run(1, 0, 0, 1'b0, 80);
      idle(2);
      cfg_out_bytes = 4'd0;
      idle(2);
      exp_bytes = 8;
      run(1, 0, 0, 1'b0, 88);
      check("t5_beat64", beat_log[64], 64'h00000000C3C2C1C0);
      check("t5_beat80", beat_log[80], 64'h0706050403020100);
      check("t5_beat_cnt", beat_cnt, 32'd88);

`ifdef STREAM_GEARBOX_LAST_EN
      // Frame flush: exact multiple, then a 1-byte remainder.
      reset_dut();
      cfg_out_bytes = 4'd8;
      exp_bytes     = 8;
      run(1, 0, 0, 1'b1, 7);
      m_ready = 1'b0;
      check("t4_s_ready_pending", s_ready, 1'b0);
      check("t4_final_last", m_last, 1'b1);
      check("t4_final_keep", m_keep, 8'hFF);
      step();
      check("t4_s_ready_stall", s_ready, 1'b0);
      run(0, 0, 0, 1'b0, 8);
      check("t4_s_ready_after", s_ready, 1'b1);
      reset_dut();
      cfg_out_bytes = 4'd7;
      exp_bytes     = 7;
      run(1, 0, 0, 1'b1, 10);
      check("t4_beat10_data", beat_log[9], 64'h000000000000003F);
      check("t4_beat10_keep", last_keep, 8'h01);
      check("t4_beat10_last", last_last, 1'b1);
      idle(2);
      check("t4_idle_s_ready", s_ready, 1'b1);
`endif

      // Reset while a beat is stalled and bytes are buffered.
      reset_dut();
      salt          = 0;
      cfg_out_bytes = 4'd7;
      exp_bytes     = 7;
      run(1, 0, 0, 1'b0, 3);
      m_ready = 1'b0;
      step();
      step();
      check("t6_pre_m_valid", m_valid, 1'b1);
      rst = 1'b1;
      step();
      check("t6_m_valid", m_valid, 1'b0);
      check("t6_s_ready", s_ready, 1'b1);
      check("t6_beat_cnt", beat_cnt, 32'd0);
      rst = 1'b0;
      clear_model();
      salt = 100;
      run(1, 0, 0, 1'b0, 9);
      check("t6_first_beat", beat_log[0], 64'h006A696867666564);
      check("t6_beat_cnt_after", beat_cnt, 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
